// File: rtl/freq_cnt_pkg.sv
// Shared types and helpers for the gated period/pulse-width counter.
// Holds the channel FSM encoding and the measurement-mode constants.
package freq_cnt_pkg;

  typedef enum logic [1:0] {
    FC_IDLE       = 2'd0,
    FC_WAIT_START = 2'd1,
    FC_COUNT      = 2'd2
  } fc_state_t;

  localparam logic FC_MODE_HIGH   = 1'b0;
  localparam logic FC_MODE_PERIOD = 1'b1;

  // Period mode closes on the next rising edge; high mode closes on the falling edge.
  function automatic logic fc_end_event(input logic mode, input logic rise, input logic fall);
    return (mode == FC_MODE_PERIOD) ? rise : fall;
  endfunction

endpackage

// File: rtl/freq_gate_counter_if.sv
// Signal bundle for freq_gate_counter: measurement inputs, per-channel controls,
// packed results/flags and a packed per-channel FSM state for observation.
interface freq_gate_counter_if #(
    parameter int CNT_W    = 16,
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0]       sig_in;
    logic [CHANNELS-1:0]       arm;
    logic [CHANNELS-1:0]       clear;
    logic                      mode_period;
    logic                      continuous;
    logic [CHANNELS*CNT_W-1:0] result;
    logic [CHANNELS-1:0]       ovf;
    logic [CHANNELS-1:0]       valid;
    logic [CHANNELS-1:0]       busy;
    logic [2*CHANNELS-1:0]     dbg_state;

    // Handshake: valid[k] is a single-cycle strobe; result/ovf of channel k are
    // updated on the same edge and hold until the next strobe. No back-pressure.
    modport master (
        output sig_in, arm, clear, mode_period, continuous,
        input  result, ovf, valid, busy, dbg_state
    );

    modport slave (
        input  sig_in, arm, clear, mode_period, continuous,
        output result, ovf, valid, busy, dbg_state
    );
endinterface

// File: rtl/freq_chan.sv
// One measurement channel: input synchroniser, edge detect, FSM, saturating
// counter and registered result with single-cycle valid strobe.
module freq_chan
    import freq_cnt_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_sig,
    input  logic             i_arm,
    input  logic             i_clear,
    input  logic             i_mode_period,
    input  logic             i_continuous,
    output logic [CNT_W-1:0] o_result,
    output logic             o_ovf,
    output logic             o_valid,
    output logic             o_busy,
    output fc_state_t        o_state
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_s_d;
    fc_state_t              r_state;
    fc_state_t              w_next;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_sat;
    logic                   r_mode;
    logic                   r_cont;
    logic [CNT_W-1:0]       r_result;
    logic                   r_ovf;
    logic                   r_valid;
    logic                   w_s;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_end;

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign w_rise = w_s & ~r_s_d;
    assign w_fall = ~w_s & r_s_d;
    assign w_end  = (r_state == FC_COUNT) && fc_end_event(r_mode, w_rise, w_fall);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_s_d  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig};
            r_s_d  <= w_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= FC_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            FC_IDLE:       if (i_arm) w_next = FC_WAIT_START;
            FC_WAIT_START: if (w_rise) w_next = FC_COUNT;
            FC_COUNT: begin
                if (w_end) begin
                    if (r_cont && r_mode == FC_MODE_PERIOD) w_next = FC_COUNT;
                    else if (r_cont)                          w_next = FC_WAIT_START;
                    else                                      w_next = FC_IDLE;
                end
            end
            default:       w_next = FC_IDLE;
        endcase
        if (i_clear) w_next = FC_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_sat    <= 1'b0;
            r_mode   <= FC_MODE_HIGH;
            r_cont   <= 1'b0;
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (i_clear) begin
                r_cnt <= '0;
                r_sat <= 1'b0;
            end else begin
                case (r_state)
                    FC_IDLE: begin
                        if (i_arm) begin
                            r_mode <= i_mode_period;
                            r_cont <= i_continuous;
                        end
                    end
                    FC_WAIT_START: begin
                        if (w_rise) r_cnt <= CNT_W'(1);
                    end
                    FC_COUNT: begin
                        if (w_end) begin
                            r_result <= r_cnt;
                            r_ovf    <= r_sat;
                            r_valid  <= 1'b1;
                            r_sat    <= 1'b0;
                            // Back-to-back periods restart at 1 so no cycle is lost.
                            r_cnt    <= (r_cont && r_mode == FC_MODE_PERIOD) ? CNT_W'(1) : '0;
                        end else if (&r_cnt) begin
                            r_sat <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: r_cnt <= '0;
                endcase
            end
        end
    end

    assign o_result = r_result;
    assign o_ovf    = r_ovf;
    assign o_valid  = r_valid;
    assign o_busy   = (r_state != FC_IDLE);
    assign o_state  = r_state;

endmodule

// File: rtl/freq_gate_counter.sv
// Multi-channel gated period/pulse-width counter: one freq_chan per input,
// outputs packed onto the interface bundle.
module freq_gate_counter
    import freq_cnt_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2
) (
    input logic                clk,
    input logic                rst_n,
    freq_gate_counter_if.slave bus
);

    logic [CNT_W-1:0] w_result [CHANNELS];
    logic             w_ovf    [CHANNELS];
    logic             w_valid  [CHANNELS];
    logic             w_busy   [CHANNELS];
    fc_state_t        w_state  [CHANNELS];

    for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
        freq_chan #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_chan (
            .clk           (clk),
            .rst_n         (rst_n),
            .i_sig         (bus.sig_in[k]),
            .i_arm         (bus.arm[k]),
            .i_clear       (bus.clear[k]),
            .i_mode_period (bus.mode_period),
            .i_continuous  (bus.continuous),
            .o_result      (w_result[k]),
            .o_ovf         (w_ovf[k]),
            .o_valid       (w_valid[k]),
            .o_busy        (w_busy[k]),
            .o_state       (w_state[k])
        );
    end

    always_comb begin
        bus.result    = '0;
        bus.ovf       = '0;
        bus.valid     = '0;
        bus.busy      = '0;
        bus.dbg_state = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            bus.result[k*CNT_W +: CNT_W] = w_result[k];
            bus.ovf[k]                   = w_ovf[k];
            bus.valid[k]                 = w_valid[k];
            bus.busy[k]                  = w_busy[k];
            bus.dbg_state[2*k +: 2]      = w_state[k];
        end
    end

endmodule

// File: tb/tb_freq_gate_counter.sv
// Directed bench for freq_gate_counter: a 4-channel 16-bit instance and a
// 1-channel 4-bit instance for saturation; valid strobes are logged and checked.
module tb_freq_gate_counter;

  typedef struct {
    int          ch;
    int          cyc;
    logic [15:0] res;
    logic        ovf;
  } ev_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_cmp;
  int   n_err;
  ev_t  ev_q[$];

  freq_gate_counter_if #(.CNT_W(16), .CHANNELS(4)) bus ();
  freq_gate_counter_if #(.CNT_W(4), .CHANNELS(1))  sbus ();

  freq_gate_counter #(.CNT_W(16), .CHANNELS(4), .SYNC_STAGES(2)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  freq_gate_counter #(.CNT_W(4), .CHANNELS(1), .SYNC_STAGES(2)) u_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sbus)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // valid-strobe logger; channel 4 is the saturation instance
  always @(posedge clk) begin
    #2;
    for (int k = 0; k < 4; k++) begin
      if (bus.valid[k] === 1'b1) ev_q.push_back('{k, cyc, bus.result[k*16 +: 16], bus.ovf[k]});
    end
    if (sbus.valid[0] === 1'b1) ev_q.push_back('{4, cyc, {12'd0, sbus.result}, sbus.ovf[0]});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic get_ev(input int ch, input int budget, output bit found, output ev_t ev);
    int idx;
    found = 1'b0;
    ev    = '{-1, 0, 16'd0, 1'b0};
    for (int i = 0; i <= budget && !found; i++) begin
      idx = -1;
      for (int j = 0; j < ev_q.size(); j++) begin
        if (idx < 0 && ev_q[j].ch == ch) idx = j;
      end
      if (idx >= 0) begin
        ev = ev_q[idx];
        ev_q.delete(idx);
        found = 1'b1;
      end else if (i < budget) begin
        @(negedge clk);
      end
    end
  endtask

  task automatic count_ch(input int ch, output int n);
    n = 0;
    for (int j = 0; j < ev_q.size(); j++) if (ev_q[j].ch == ch) n++;
  endtask

  initial begin : stim
    bit   found;
    ev_t  ev;
    int   p;
    int   n;
    int   prev;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.sig_in = '0; bus.arm = '0; bus.clear = '0;
    bus.mode_period = 1'b0; bus.continuous = 1'b0;
    sbus.sig_in = '0; sbus.arm = '0; sbus.clear = '0;
    sbus.mode_period = 1'b0; sbus.continuous = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // reset state
    chk("rst_result", bus.result, 64'd0);
    chk("rst_ovf",    bus.ovf,    64'd0);
    chk("rst_valid",  bus.valid,  64'd0);
    chk("rst_busy",   bus.busy,   64'd0);
    chk("rst_state",  bus.dbg_state, 64'd0);
    chk("rst_sat_result", sbus.result, 64'd0);

    // high mode, single-shot, 37-cycle pulse on ch0
    bus.arm[0] = 1'b1;
    tick(1);
    bus.arm[0] = 1'b0;
    chk("hi_busy_rise", bus.busy[0], 64'd1);
    tick(2);
    p = cyc;
    bus.sig_in[0] = 1'b1;
    tick(37);
    bus.sig_in[0] = 1'b0;
    get_ev(0, 20, found, ev);
    chk("hi_found",  found, 64'd1);
    chk("hi_result", ev.res, 64'd37);
    chk("hi_ovf",    ev.ovf, 64'd0);
    chk("hi_latency", ev.cyc - p, 64'd40);
    chk("hi_busy_fall", bus.busy[0], 64'd0);
    tick(1);
    chk("hi_valid_one_cycle", bus.valid[0], 64'd0);
    tick(5);
    count_ch(0, n);
    chk("hi_single_strobe", n, 64'd0);

    // period mode, continuous, period 100 on ch1; mode changed after arming
    bus.mode_period = 1'b1;
    bus.continuous  = 1'b1;
    bus.arm[1] = 1'b1;
    tick(1);
    bus.arm[1] = 1'b0;
    bus.mode_period = 1'b0;
    bus.continuous  = 1'b0;
    tick(2);
    p = cyc;
    for (int r = 0; r < 5; r++) begin
      bus.sig_in[1] = 1'b1;
      tick(50);
      bus.sig_in[1] = 1'b0;
      tick(50);
    end
    prev = p + 3;
    for (int r = 0; r < 4; r++) begin
      get_ev(1, 5, found, ev);
      chk("per_found",  found, 64'd1);
      chk("per_result", ev.res, 64'd100);
      chk("per_spacing", ev.cyc - prev, 64'd100);
      prev = ev.cyc;
    end
    chk("per_busy", bus.busy[1], 64'd1);
    bus.clear[1] = 1'b1;
    tick(1);
    bus.clear[1] = 1'b0;
    chk("per_clear_busy", bus.busy[1], 64'd0);
    count_ch(1, n);
    chk("per_no_extra", n, 64'd0);

    // saturation on the 4-bit instance, continuous high mode
    sbus.mode_period = 1'b0;
    sbus.continuous  = 1'b1;
    sbus.arm[0] = 1'b1;
    tick(1);
    sbus.arm[0] = 1'b0;
    tick(2);
    sbus.sig_in[0] = 1'b1;
    tick(20);
    sbus.sig_in[0] = 1'b0;
    get_ev(4, 10, found, ev);
    chk("sat_found",  found, 64'd1);
    chk("sat_result", ev.res, 64'd15);
    chk("sat_ovf",    ev.ovf, 64'd1);
    tick(4);
    chk("sat_rearmed_busy", sbus.busy[0], 64'd1);
    sbus.sig_in[0] = 1'b1;
    tick(5);
    sbus.sig_in[0] = 1'b0;
    get_ev(4, 10, found, ev);
    chk("sat2_found",  found, 64'd1);
    chk("sat2_result", ev.res, 64'd5);
    chk("sat2_ovf",    ev.ovf, 64'd0);
    sbus.clear[0] = 1'b1;
    tick(1);
    sbus.clear[0] = 1'b0;
    chk("sat_clear_busy", sbus.busy[0], 64'd0);

    // clear during COUNT keeps the prior result of 42 on ch2
    bus.arm[2] = 1'b1;
    tick(1);
    bus.arm[2] = 1'b0;
    tick(2);
    bus.sig_in[2] = 1'b1;
    tick(42);
    bus.sig_in[2] = 1'b0;
    get_ev(2, 10, found, ev);
    chk("clr_prior_result", ev.res, 64'd42);
    tick(3);
    bus.arm[2] = 1'b1;
    tick(1);
    bus.arm[2] = 1'b0;
    tick(2);
    bus.sig_in[2] = 1'b1;
    tick(10);
    chk("clr_state_count", bus.dbg_state[5:4], 64'd2);
    bus.clear[2] = 1'b1;
    tick(1);
    bus.clear[2] = 1'b0;
    chk("clr_busy",   bus.busy[2], 64'd0);
    chk("clr_result", bus.result[47:32], 64'd42);
    bus.sig_in[2] = 1'b0;
    tick(10);
    count_ch(2, n);
    chk("clr_no_valid", n, 64'd0);
    bus.arm[2]   = 1'b1;
    bus.clear[2] = 1'b1;
    tick(1);
    bus.arm[2]   = 1'b0;
    bus.clear[2] = 1'b0;
    chk("arm_clear_busy", bus.busy[2], 64'd0);
    tick(1);
    chk("arm_clear_busy2", bus.busy[2], 64'd0);

    // independence: simultaneous rises, widths 3, 8, 64, 200
    bus.arm = 4'hF;
    tick(1);
    bus.arm = 4'h0;
    tick(2);
    p = cyc;
    bus.sig_in = 4'hF;
    tick(3);
    bus.sig_in[0] = 1'b0;
    tick(5);
    bus.sig_in[1] = 1'b0;
    tick(56);
    bus.sig_in[2] = 1'b0;
    tick(136);
    bus.sig_in[3] = 1'b0;
    get_ev(0, 10, found, ev);
    chk("ind0_result", ev.res, 64'd3);
    chk("ind0_cycle",  ev.cyc - p, 64'd6);
    get_ev(1, 10, found, ev);
    chk("ind1_result", ev.res, 64'd8);
    chk("ind1_cycle",  ev.cyc - p, 64'd11);
    get_ev(2, 10, found, ev);
    chk("ind2_result", ev.res, 64'd64);
    chk("ind2_cycle",  ev.cyc - p, 64'd67);
    get_ev(3, 10, found, ev);
    chk("ind3_found",  found, 64'd1);
    chk("ind3_result", ev.res, 64'd200);
    chk("ind3_cycle",  ev.cyc - p, 64'd203);
    tick(2);
    chk("ind_busy_all", bus.busy, 64'd0);

    // asynchronous reset mid-COUNT on ch0
    bus.arm[0] = 1'b1;
    tick(1);
    bus.arm[0] = 1'b0;
    tick(2);
    bus.sig_in[0] = 1'b1;
    tick(10);
    chk("mid_state_count", bus.dbg_state[1:0], 64'd2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",   bus.busy,   64'd0);
    chk("mid_rst_result", bus.result, 64'd0);
    chk("mid_rst_valid",  bus.valid,  64'd0);
    chk("mid_rst_ovf",    bus.ovf,    64'd0);
    tick(2);
    bus.sig_in[0] = 1'b0;
    rst_n = 1'b1;
    tick(12);
    chk("mid_rst_no_valid", ev_q.size(), 64'd0);
    chk("mid_rst_busy_after", bus.busy, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/freq_gate_counter.md
# freq_gate_counter

Multi-channel gated period/pulse-width counter for the frequency-counter datapath. Each channel takes an asynchronous input, synchronises it, and counts `clk` cycles across either the high phase or one full period of that input. Each completed measurement is published as a saturating result with an overflow flag and a one-cycle valid strobe. It generalises the single-window counter to N channels, configurable width and measurement mode, with single-shot and continuous operation.

## Interface
- `CNT_W`, 16: counter and result width, minimum 4.
- `CHANNELS`, 4: number of independent input channels, minimum 1.
- `SYNC_STAGES`, 2: synchroniser flops per channel, minimum 2.

- `clk`  in  1  measurement clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `sig_in`  in  CHANNELS  asynchronous signals under measurement.
- `arm`  in  CHANNELS  per-channel start request, level-sampled each cycle.
- `clear`  in  CHANNELS  per-channel abort, synchronous.
- `mode_period`  in  1  1 = rising-to-rising period; 0 = high time (rising-to-falling).
- `continuous`  in  1  1 = re-arm automatically after each result.
- `result`  out  CHANNELS*CNT_W  channel k occupies bits [k*CNT_W +: CNT_W].
- `ovf`  out  CHANNELS  result of channel k saturated.
- `valid`  out  CHANNELS  one-cycle strobe, coincident with `result`/`ovf` update.
- `busy`  out  CHANNELS  channel not in IDLE.

## Operation
- Synchroniser: `sig_in[k]` passes through SYNC_STAGES flops to give `s`, plus one more flop to give `s_d`.
  - rise = s & ~s_d.
  - fall = ~s & s_d.
- Per-channel FSM states: IDLE, WAIT_START, COUNT.
  - IDLE → WAIT_START when `arm[k]`=1. `mode_period` and `continuous` are latched into channel registers at this transition. Later changes are ignored until the channel returns to IDLE.
  - WAIT_START → COUNT on rise. `cnt` <= 1.
  - In COUNT with no end event: `cnt` <= cnt+1. At all-ones, `cnt` holds and the sticky internal `sat` bit is set.
  - End event is fall in high mode and rise in period mode. On the end event:
    - `result` <= cnt.
    - `ovf` <= sat.
    - `valid` pulses.
    - `sat` is cleared.
  - Next state after the end event:
    - Period mode with continuous: stay in COUNT with `cnt` <= 1, so back-to-back periods are measured with no gap.
    - High mode with continuous: go to WAIT_START.
    - Not continuous: go to IDLE.
- Measured value is the number of synchronised cycles from the start event (inclusive) to the end event (exclusive). A high pulse of N synchronised cycles yields N.
- `clear[k]` from any state:
  - Next state is IDLE, `cnt` is cleared, `sat` is cleared.
  - `result` and `ovf` are retained.
  - No `valid` pulse is issued.
- Priority: `clear` > end event > `arm`.
  - `arm` while busy is ignored.
  - `clear` and `arm` in the same cycle results in IDLE.
- Channels are fully independent. Simultaneous events on different channels never interact.

## Timing
- Reset values:
  - `result` = 0, `ovf` = 0, `valid` = 0, `busy` = 0.
  - All FSMs are in IDLE, `cnt` = 0, synchroniser flops = 0.
- `sig_in` edge to start/end event: SYNC_STAGES cycles after the first flop captures it, so event jitter is ±1 `clk`.
- End event to `result`/`valid` visible at the outputs: 1 cycle. These are registered outputs with no combinational path from inputs.
- `busy` rises the cycle after `arm` is accepted, and falls the cycle after the end event (single-shot) or after `clear`.
- Reset asserted mid-measurement immediately returns all state to the reset values, with no valid strobe.
- A rise seen in the same cycle as the IDLE→WAIT_START transition is not used. The first usable start event comes the cycle after arming.

## Structure
- Package `freq_cnt_pkg`:
  - FSM state enum `fc_state_t`.
  - Mode constants `FC_MODE_HIGH`, `FC_MODE_PERIOD`.
- Sub-module `freq_chan`, one channel: synchroniser, edge detect, FSM, saturating counter, result register.
- The top level is a generate loop over CHANNELS plus output packing.

## Test plan
- Reset: assert `rst_n`=0 mid-COUNT on channel 0 -> all outputs 0, `busy`=0, no `valid` after release.
- High mode, single-shot, CNT_W=16: `sig_in[0]` high for exactly 37 `clk` -> one `valid[0]`, `result` ch0 = 37, `ovf`=0, `busy` falls.
- Period mode, continuous: ch1 driven with a period of 100 `clk` for 4 periods -> `valid[1]` every 100 cycles, each `result` = 100, no gaps.
- Saturation, CNT_W=4: high pulse of 20 cycles -> `result` = 15, `ovf`=1. The next 5-cycle pulse in continuous high mode -> `result` = 5, `ovf`=0.
- Clear and priority: `clear[2]` asserted during COUNT with a prior `result` of 42 -> IDLE, `result` stays 42, no `valid`. `arm` and `clear` in the same cycle -> `busy` stays 0.
- Independence: simultaneous rises on all 4 channels with different widths (3, 8, 64, 200) -> each channel reports its own width, with `valid` strobes at their respective end cycles.
